// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, default baud/frame settings and
// receiver sampling constants, so both link ends stay in step.
package uart_pkg;

    localparam int unsigned DEF_CLKS_PER_BIT = 434;  // 50 MHz / 115200
    localparam int unsigned DEF_DATA_BITS    = 8;
    localparam int unsigned DEF_STOP_BITS    = 1;

    // Receiver: two-flop synchroniser on rxd, then sample each bit mid-period.
    localparam int unsigned RX_SYNC_STAGES   = 2;
    localparam int unsigned RX_MID_SAMPLE    = DEF_CLKS_PER_BIT / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last clock of
// each period. Held at zero while clear is high.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic tick_next_c
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;

    // Next count: restart on clear, wrap at the end of the bit period.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Early view of tick so the owner can register flags for the final clock.
    assign tick_next_c = (cnt_d == LAST);

    // Counter and registered tick, valid while the count sits at LAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == LAST);
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1-style UART transmitter: valid/ready byte intake, start bit, data
// LSB-first, stop bit(s). txd is driven straight from a flop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = DEF_DATA_BITS,
    parameter int unsigned STOP_BITS    = DEF_STOP_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_done,
    output logic                 txd
);

    localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    generate
        if ((CLKS_PER_BIT < 2) || (DATA_BITS < 5) || (DATA_BITS > 8) ||
            ((STOP_BITS != 1) && (STOP_BITS != 2))) begin : g_bad_params
            $error("uart_tx: illegal CLKS_PER_BIT/DATA_BITS/STOP_BITS");
        end
    endgenerate

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [BIT_W-1:0]     bit_idx_q;
    logic                 txd_q;
    logic                 ready_q;
    logic                 done_q;

    logic baud_clear;
    logic bit_tick;
    logic bit_tick_next_c;
    logic accept;
    logic last_stop;

    assign accept     = tx_valid && ready_q;
    assign baud_clear = (state_q == IDLE);
    assign last_stop  = (state_q == STOP) && (bit_idx_q == LAST_STOP);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk         (clk),
        .rst         (rst),
        .clear       (baud_clear),
        .tick        (bit_tick),
        .tick_next_c (bit_tick_next_c)
    );

    // Frame sequencer: shift register, bit index and registered line/handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            txd_q     <= 1'b1;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_q   <= tx_data;
                        bit_idx_q <= '0;
                        txd_q     <= 1'b0;
                        ready_q   <= 1'b0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        txd_q     <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_idx_q == LAST_DATA) begin
                            txd_q     <= 1'b1;
                            bit_idx_q <= '0;
                            state_q   <= STOP;
                        end else begin
                            txd_q     <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= bit_idx_q + BIT_W'(1);
                        end
                    end
                end
                STOP: begin
                    // Raise done/ready for exactly the final clock of the frame.
                    if (last_stop && bit_tick_next_c) begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                    end
                    if (bit_tick) begin
                        if (last_stop) begin
                            if (accept) begin
                                shift_q   <= tx_data;
                                bit_idx_q <= '0;
                                txd_q     <= 1'b0;
                                ready_q   <= 1'b0;
                                state_q   <= START;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + BIT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    txd_q   <= 1'b1;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign txd      = txd_q;
    assign tx_ready = ready_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: cycle-exact waveform checks against hand-built frames,
// plus a behavioural mid-bit receiver standing in for the far end of the link.
module tb_uart_tx;

    localparam int CPB   = 434;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       txd;

    int n_checks = 0;
    int n_fail   = 0;
    int rst_cnt  = 0;
    int rx_ferr  = 0;
    logic [7:0] rx_q[$];

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .STOP_BITS    (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .txd      (txd)
    );

    always #1 clk = ~clk;

    // Count sampled resets so the receiver model can abandon a frame.
    always @(posedge clk) if (rst) rst_cnt <= rst_cnt + 1;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;     // bit i = i-th serial bit (start first)
        logic [7:0] rx;
        int         pulse_at;  // cycle to pulse tx_valid mid-frame, -1 = none
        logic [7:0] pulse_d;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic rx_wait(input int n, input int snap, output bit ab);
        ab = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rst_cnt != snap) begin
                ab = 1'b1;
                return;
            end
        end
    endtask

    // Receiver model: falling edge, mid-bit sampling, stop-bit framing check.
    initial begin : rx_model
        logic       prev;
        logic [7:0] sh;
        int         snap;
        bit         ab;
        prev = 1'b1;
        sh   = '0;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && txd === 1'b0) begin
                snap = rst_cnt;
                rx_wait(CPB / 2, snap, ab);
                if (!ab && txd !== 1'b0) begin
                    rx_ferr++;
                    ab = 1'b1;
                end
                for (int i = 0; i < 8; i++) begin
                    if (!ab) begin
                        rx_wait(CPB, snap, ab);
                        sh[i] = txd;
                    end
                end
                if (!ab) begin
                    rx_wait(CPB, snap, ab);
                    if (!ab) begin
                        if (txd !== 1'b1) rx_ferr++;
                        else rx_q.push_back(sh);
                    end
                end
            end
            prev = txd;
        end
    end

    // Send one frame (or two back-to-back) and compare every cycle of the window.
    task automatic run_tx(input logic [7:0] d0, input logic [9:0] f0,
                          input logic [7:0] d1, input logic [9:0] f1,
                          input int nfr, input int pulse_at, input logic [7:0] pulse_d,
                          input string tag);
        int wave_err  = 0;
        int ready_err = 0;
        int done_cnt  = 0;
        int done_pos  = -1;
        logic [9:0] fr;
        logic exp_txd, exp_ready;
        check({tag, " ready before send"}, 32'(tx_ready), 32'd1);
        tx_data  = d0;
        tx_valid = 1'b1;
        for (int k = 0; k <= nfr * FRAME; k++) begin
            @(negedge clk);
            if (k < nfr * FRAME) begin
                fr        = (k >= FRAME) ? f1 : f0;
                exp_txd   = fr[(k % FRAME) / CPB];
                exp_ready = ((k % FRAME) == FRAME - 1);
            end else begin
                exp_txd   = 1'b1;
                exp_ready = 1'b1;
            end
            if (txd !== exp_txd) wave_err++;
            if (tx_ready !== exp_ready) ready_err++;
            if (tx_done === 1'b1) begin
                done_cnt++;
                if (done_pos < 0) done_pos = k;
            end
            if (k == 0 && nfr == 2) tx_data = d1;
            if ((k == 0 && nfr == 1) || (k == FRAME && nfr == 2)) begin
                tx_valid = 1'b0;
                tx_data  = ~tx_data;
            end
            if (k == pulse_at) begin
                tx_valid = 1'b1;
                tx_data  = pulse_d;
            end
            if (pulse_at >= 0 && k == pulse_at + 1) tx_valid = 1'b0;
        end
        check({tag, " txd waveform errors"}, 32'(wave_err), 32'd0);
        check({tag, " tx_ready errors"}, 32'(ready_err), 32'd0);
        check({tag, " tx_done pulses"}, 32'(done_cnt), 32'(nfr));
        check({tag, " first tx_done cycle"}, 32'(done_pos), 32'(FRAME - 1));
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, frame: 10'h34A, rx: 8'hA5, pulse_at: -1,  pulse_d: 8'h00};
        vecs[1] = '{data: 8'h55, frame: 10'h2AA, rx: 8'h55, pulse_at: -1,  pulse_d: 8'h00};
        vecs[2] = '{data: 8'h00, frame: 10'h200, rx: 8'h00, pulse_at: -1,  pulse_d: 8'h00};
        vecs[3] = '{data: 8'hFF, frame: 10'h3FE, rx: 8'hFF, pulse_at: -1,  pulse_d: 8'h00};
        vecs[4] = '{data: 8'h3C, frame: 10'h278, rx: 8'h3C, pulse_at: -1,  pulse_d: 8'h00};
        vecs[5] = '{data: 8'h81, frame: 10'h302, rx: 8'h81, pulse_at: 999, pulse_d: 8'h12};

        // Reset held with a pending request: line idle, nothing accepted.
        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("reset txd c%0d", i), 32'(txd), 32'd1);
            check($sformatf("reset tx_ready c%0d", i), 32'(tx_ready), 32'd1);
            check($sformatf("reset tx_done c%0d", i), 32'(tx_done), 32'd0);
        end
        rst      = 1'b0;
        tx_valid = 1'b0;
        @(negedge clk);
        check("post-reset txd idle", 32'(txd), 32'd1);
        @(negedge clk);

        // Single frames, including a busy-time tx_valid pulse.
        for (int i = 0; i < 6; i++) begin
            run_tx(vecs[i].data, vecs[i].frame, vecs[i].data, vecs[i].frame,
                   1, vecs[i].pulse_at, vecs[i].pulse_d, $sformatf("vec%0d", i));
            check($sformatf("vec%0d rx count", i), 32'(rx_q.size()), 32'd1);
            if (rx_q.size() > 0) check($sformatf("vec%0d rx byte", i), 32'(rx_q.pop_front()), 32'(vecs[i].rx));
            @(negedge clk);
        end

        // Back-to-back: second start bit follows first tx_done immediately.
        run_tx(8'h00, 10'h200, 8'hFF, 10'h3FE, 2, -1, 8'h00, "b2b");
        check("b2b rx count", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() > 0) check("b2b rx byte0", 32'(rx_q.pop_front()), 32'h00);
        if (rx_q.size() > 0) check("b2b rx byte1", 32'(rx_q.pop_front()), 32'hFF);
        @(negedge clk);

        // Reset mid-frame: abandoned with no tx_done, link recovers.
        begin
            int txd_low = 0;
            int dones   = 0;
            tx_data  = 8'hF0;
            tx_valid = 1'b1;
            for (int k = 0; k < 2000; k++) begin
                @(negedge clk);
                if (k == 0) tx_valid = 1'b0;
                if (k == 1999) rst = 1'b1;
            end
            @(negedge clk);
            rst = 1'b0;
            check("midrst txd", 32'(txd), 32'd1);
            check("midrst tx_ready", 32'(tx_ready), 32'd1);
            check("midrst tx_done", 32'(tx_done), 32'd0);
            for (int k = 0; k < 3000; k++) begin
                @(negedge clk);
                if (txd !== 1'b1) txd_low++;
                if (tx_done !== 1'b0) dones++;
            end
            check("midrst txd stays idle", 32'(txd_low), 32'd0);
            check("midrst no tx_done", 32'(dones), 32'd0);
            check("midrst no rx byte", 32'(rx_q.size()), 32'd0);
        end
        run_tx(8'h0F, 10'h21E, 8'h0F, 10'h21E, 1, -1, 8'h00, "after_rst");
        check("after_rst rx count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("after_rst rx byte", 32'(rx_q.pop_front()), 32'h0F);

        check("receiver framing errors", 32'(rx_ferr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
